// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// It also produces a saturated signed display value for the downstream 5-bit decoder.
module booth_seq_multiplier #(
   parameter int N      = 4,
   parameter int DISP_W = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [N-1:0]        multiplicand_i,
   input  logic [N-1:0]        multiplier_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [2*N-1:0]      product_o,
   output logic [DISP_W-1:0]   disp_value_o,
   output logic                disp_ovf_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   localparam int CNT_W = $clog2(N + 1);
   localparam int CW    = (2 * N > DISP_W) ? 2 * N : DISP_W;
   localparam logic signed [CW-1:0] SAT_MAX = CW'((2 ** (DISP_W - 1)) - 1);
   localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

   state_e               state_q, state_d;
   logic [N:0]           m_q, a_q;
   logic [N-1:0]         q_q;
   logic                 qm1_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 done_q, disp_ovf_q;
   logic [2*N-1:0]       product_q;
   logic [DISP_W-1:0]    disp_value_q;

   logic                 load_en, iter_en, finish_en;
   logic [N:0]           a_sum;
   logic [2*N-1:0]       prod_full;
   logic signed [CW-1:0] prod_ext;
   logic [DISP_W-1:0]    disp_d;
   logic                 ovf_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = CALC;
         CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o    = 1'b0;
      load_en   = 1'b0;
      iter_en   = 1'b0;
      finish_en = 1'b0;
      case (state_q)
         IDLE:    load_en   = start_i;
         CALC:    begin busy_o = 1'b1; iter_en = 1'b1; end
         DONE:    finish_en = 1'b1;
         default: ;
      endcase
   end

   // Booth recoding of {Q[0], q_-1}; the N+1-bit accumulator absorbs -(-2^(N-1)).
   always_comb begin
      a_sum = a_q;
      case ({q_q[0], qm1_q})
         2'b10:   a_sum = a_q - m_q;
         2'b01:   a_sum = a_q + m_q;
         default: a_sum = a_q;
      endcase
   end

   assign prod_full = {a_q[N-1:0], q_q};
   assign prod_ext  = CW'($signed(prod_full));

   always_comb begin
      disp_d = prod_ext[DISP_W-1:0];
      ovf_d  = 1'b0;
      if (prod_ext > SAT_MAX) begin
         disp_d = SAT_MAX[DISP_W-1:0];
         ovf_d  = 1'b1;
      end else if (prod_ext < SAT_MIN) begin
         disp_d = SAT_MIN[DISP_W-1:0];
         ovf_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_q          <= '0;
         a_q          <= '0;
         q_q          <= '0;
         qm1_q        <= 1'b0;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         product_q    <= '0;
         disp_value_q <= '0;
         disp_ovf_q   <= 1'b0;
      end else begin
         done_q <= finish_en;
         if (load_en) begin
            m_q   <= {multiplicand_i[N-1], multiplicand_i};
            a_q   <= '0;
            q_q   <= multiplier_i;
            qm1_q <= 1'b0;
            cnt_q <= CNT_W'(N);
         end
         if (iter_en) begin
            a_q   <= {a_sum[N], a_sum[N:1]};
            q_q   <= {a_sum[0], q_q[N-1:1]};
            qm1_q <= q_q[0];
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (finish_en) begin
            product_q    <= prod_full;
            disp_value_q <= disp_d;
            disp_ovf_q   <= ovf_d;
         end
      end
   end

   assign done_o       = done_q;
   assign product_o    = product_q;
   assign disp_value_o = disp_value_q;
   assign disp_ovf_o   = disp_ovf_q;

endmodule
